// File: rtl/aq_fadd_pkg.sv
// Shared types and constants for the FP adder pipeline: format/rounding-mode
// encodings, per-format exponent limits, fflags bit positions and the EX3 register image.
package aq_fadd_pkg;

  localparam int RSLT_W = 64;
  localparam int FLAG_W = 5;

  typedef enum logic [1:0] {
    FMT_D  = 2'b00,
    FMT_S  = 2'b01,
    FMT_H  = 2'b10,
    FMT_BF = 2'b11
  } fmt_e;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  localparam logic [11:0] EMAX_D  = 12'd2047;
  localparam logic [11:0] EMAX_S  = 12'd255;
  localparam logic [11:0] EMAX_H  = 12'd31;
  localparam logic [11:0] EMAX_BF = 12'd255;

  localparam int FRAC_W_D  = 52;
  localparam int FRAC_W_S  = 23;
  localparam int FRAC_W_H  = 10;
  localparam int FRAC_W_BF = 7;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef struct packed {
    logic [1:0]        fmt;
    logic [2:0]        rm;
    logic              sign;
    logic [11:0]       expnt;
    logic [53:0]       mant_d;
    logic [24:0]       mant_s;
    logic [11:0]       mant_h;
    logic [8:0]        mant_bf;
    logic              nx;
    logic              spec_vld;
    logic [RSLT_W-1:0] spec_rslt;
    logic              spec_nv;
  } ex3_data_t;

  // Overflow saturates to infinity only when rounding points away from zero.
  function automatic logic ovfl_to_inf(input logic sign, input logic [2:0] rm);
    logic inf_v;
    inf_v = 1'b0;
    case (rm)
      RM_RNE, RM_RMM: inf_v = 1'b1;
      RM_RUP:         inf_v = ~sign;
      RM_RDN:         inf_v = sign;
      default:        inf_v = 1'b0;
    endcase
    return inf_v;
  endfunction

endpackage

// File: rtl/aq_fadd_ex3_pack_if.sv
// EX2 -> EX3 operand bundle plus the EX3 result/handshake signals.
interface aq_fadd_ex3_pack_if;
  import aq_fadd_pkg::*;

  logic              ex2_vld;
  logic [1:0]        ex2_fmt;
  logic [2:0]        ex2_rm;
  logic              ex2_act_s;
  logic [11:0]       ex2_expnt;
  logic [53:0]       ex2_double_addsub_rslt;
  logic [24:0]       ex2_single0_addsub_rslt;
  logic [11:0]       ex2_half0_addsub_rslt;
  logic [8:0]        ex2_bhalf0_addsub_rslt;
  logic              ex2_nx;
  logic              ex2_special_value_vld;
  logic [RSLT_W-1:0] ex2_special_rslt;
  logic              ex2_special_nv;
  logic              ex3_stall;
  logic              pipe_flush;
  logic              ex2_stall;
  logic              ex3_rslt_vld;
  logic [RSLT_W-1:0] ex3_rslt;
  logic [FLAG_W-1:0] ex3_fflags;

  modport master (
    output ex2_vld, ex2_fmt, ex2_rm, ex2_act_s, ex2_expnt,
           ex2_double_addsub_rslt, ex2_single0_addsub_rslt,
           ex2_half0_addsub_rslt, ex2_bhalf0_addsub_rslt, ex2_nx,
           ex2_special_value_vld, ex2_special_rslt, ex2_special_nv,
           ex3_stall, pipe_flush,
    input  ex2_stall, ex3_rslt_vld, ex3_rslt, ex3_fflags
  );

  modport slave (
    input  ex2_vld, ex2_fmt, ex2_rm, ex2_act_s, ex2_expnt,
           ex2_double_addsub_rslt, ex2_single0_addsub_rslt,
           ex2_half0_addsub_rslt, ex2_bhalf0_addsub_rslt, ex2_nx,
           ex2_special_value_vld, ex2_special_rslt, ex2_special_nv,
           ex3_stall, pipe_flush,
    output ex2_stall, ex3_rslt_vld, ex3_rslt, ex3_fflags
  );

endinterface

// File: rtl/aq_fadd_ex3_ovfl_sel.sv
// Overflow result pattern: signed infinity or largest finite value, NaN-boxed
// for the narrow formats.
module aq_fadd_ex3_ovfl_sel
  import aq_fadd_pkg::*;
(
  input  logic              sign,
  input  logic [2:0]        rm,
  input  logic [1:0]        fmt,
  output logic [RSLT_W-1:0] ovfl_rslt
);

  logic to_inf_s;

  assign to_inf_s = ovfl_to_inf(sign, rm);

  // Per-format infinity / max-finite encoding.
  always_comb begin
    ovfl_rslt = {RSLT_W{1'b0}};
    case (fmt)
      FMT_D: begin
        if (to_inf_s) ovfl_rslt = {sign, 11'h7FF, 52'd0};
        else          ovfl_rslt = {sign, 11'h7FE, {52{1'b1}}};
      end
      FMT_S: begin
        if (to_inf_s) ovfl_rslt = {32'hFFFF_FFFF, sign, 8'hFF, 23'd0};
        else          ovfl_rslt = {32'hFFFF_FFFF, sign, 8'hFE, {23{1'b1}}};
      end
      FMT_H: begin
        if (to_inf_s) ovfl_rslt = {48'hFFFF_FFFF_FFFF, sign, 5'h1F, 10'd0};
        else          ovfl_rslt = {48'hFFFF_FFFF_FFFF, sign, 5'h1E, {10{1'b1}}};
      end
      FMT_BF: begin
        if (to_inf_s) ovfl_rslt = {48'hFFFF_FFFF_FFFF, sign, 8'hFF, 7'd0};
        else          ovfl_rslt = {48'hFFFF_FFFF_FFFF, sign, 8'hFE, {7{1'b1}}};
      end
      default: ovfl_rslt = {RSLT_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/aq_fadd_ex3_pack.sv
// EX3 of the vector FP adder: one register stage over the rounded EX2 result,
// followed by exponent adjust, overflow/underflow detection and IEEE packing.
module aq_fadd_ex3_pack
  import aq_fadd_pkg::*;
(
  input  logic               forever_cpuclk,
  input  logic               cpurst,
  aq_fadd_ex3_pack_if.slave  ex_if
);

  logic              ex3_vld_r;
  ex3_data_t         data_r;
  ex3_data_t         data_nxt_s;
  logic              capture_s;
  logic              load_en_s;
  logic              carry_s;
  logic              hid_s;
  logic [51:0]       frac_s;
  logic [11:0]       emax_s;
  logic [11:0]       e_s;
  logic              ovf_s;
  logic [RSLT_W-1:0] norm_rslt_s;
  logic [RSLT_W-1:0] ovfl_rslt_s;
  logic [RSLT_W-1:0] rslt_s;
  logic [FLAG_W-1:0] fflags_s;

  assign ex_if.ex2_stall = ex3_vld_r & ex_if.ex3_stall;
  assign capture_s       = ex_if.ex2_vld & ~ex_if.ex2_stall & ~ex_if.pipe_flush;
  assign load_en_s       = capture_s | (ex3_vld_r & ~ex_if.ex3_stall);

  // Gather the EX2 operand image into the register struct.
  always_comb begin
    data_nxt_s           = '0;
    data_nxt_s.fmt       = ex_if.ex2_fmt;
    data_nxt_s.rm        = ex_if.ex2_rm;
    data_nxt_s.sign      = ex_if.ex2_act_s;
    data_nxt_s.expnt     = ex_if.ex2_expnt;
    data_nxt_s.mant_d    = ex_if.ex2_double_addsub_rslt;
    data_nxt_s.mant_s    = ex_if.ex2_single0_addsub_rslt;
    data_nxt_s.mant_h    = ex_if.ex2_half0_addsub_rslt;
    data_nxt_s.mant_bf   = ex_if.ex2_bhalf0_addsub_rslt;
    data_nxt_s.nx        = ex_if.ex2_nx;
    data_nxt_s.spec_vld  = ex_if.ex2_special_value_vld;
    data_nxt_s.spec_rslt = ex_if.ex2_special_rslt;
    data_nxt_s.spec_nv   = ex_if.ex2_special_nv;
  end

  // Valid bit: flush beats capture; a stalled op is held, otherwise it retires.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      ex3_vld_r <= 1'b0;
    end else if (ex_if.pipe_flush) begin
      ex3_vld_r <= 1'b0;
    end else if (capture_s) begin
      ex3_vld_r <= 1'b1;
    end else begin
      ex3_vld_r <= ex3_vld_r & ex_if.ex3_stall;
    end
  end

  // Data registers load on capture or drain, and hold while stalled.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      data_r <= '0;
    end else if (load_en_s) begin
      data_r <= data_nxt_s;
    end
  end

  // Select the active mantissa; a round carry shifts the fraction down one place.
  always_comb begin
    carry_s = 1'b0;
    hid_s   = 1'b0;
    frac_s  = 52'd0;
    emax_s  = EMAX_D;
    case (data_r.fmt)
      FMT_D: begin
        carry_s = data_r.mant_d[FRAC_W_D+1];
        hid_s   = data_r.mant_d[FRAC_W_D];
        emax_s  = EMAX_D;
        if (carry_s) frac_s = data_r.mant_d[FRAC_W_D:1];
        else         frac_s = data_r.mant_d[FRAC_W_D-1:0];
      end
      FMT_S: begin
        carry_s = data_r.mant_s[FRAC_W_S+1];
        hid_s   = data_r.mant_s[FRAC_W_S];
        emax_s  = EMAX_S;
        if (carry_s) frac_s = {29'd0, data_r.mant_s[FRAC_W_S:1]};
        else         frac_s = {29'd0, data_r.mant_s[FRAC_W_S-1:0]};
      end
      FMT_H: begin
        carry_s = data_r.mant_h[FRAC_W_H+1];
        hid_s   = data_r.mant_h[FRAC_W_H];
        emax_s  = EMAX_H;
        if (carry_s) frac_s = {42'd0, data_r.mant_h[FRAC_W_H:1]};
        else         frac_s = {42'd0, data_r.mant_h[FRAC_W_H-1:0]};
      end
      FMT_BF: begin
        carry_s = data_r.mant_bf[FRAC_W_BF+1];
        hid_s   = data_r.mant_bf[FRAC_W_BF];
        emax_s  = EMAX_BF;
        if (carry_s) frac_s = {45'd0, data_r.mant_bf[FRAC_W_BF:1]};
        else         frac_s = {45'd0, data_r.mant_bf[FRAC_W_BF-1:0]};
      end
      default: begin
        carry_s = 1'b0;
        hid_s   = 1'b0;
        frac_s  = 52'd0;
        emax_s  = EMAX_D;
      end
    endcase
  end

  // Exponent adjust; no hidden bit means a denormal or zero with E = 0.
  always_comb begin
    e_s = 12'd0;
    if (carry_s) begin
      e_s = data_r.expnt + 12'd1;
    end else if (hid_s) begin
      e_s = data_r.expnt;
    end else begin
      e_s = 12'd0;
    end
  end

  assign ovf_s = (e_s >= emax_s);

  // Pack sign/exponent/fraction; narrow formats are NaN-boxed.
  always_comb begin
    norm_rslt_s = {RSLT_W{1'b0}};
    case (data_r.fmt)
      FMT_D:   norm_rslt_s = {data_r.sign, e_s[10:0], frac_s};
      FMT_S:   norm_rslt_s = {32'hFFFF_FFFF, data_r.sign, e_s[7:0], frac_s[22:0]};
      FMT_H:   norm_rslt_s = {48'hFFFF_FFFF_FFFF, data_r.sign, e_s[4:0], frac_s[9:0]};
      FMT_BF:  norm_rslt_s = {48'hFFFF_FFFF_FFFF, data_r.sign, e_s[7:0], frac_s[6:0]};
      default: norm_rslt_s = {RSLT_W{1'b0}};
    endcase
  end

  aq_fadd_ex3_ovfl_sel u_ovfl_sel (
    .sign      (data_r.sign),
    .rm        (data_r.rm),
    .fmt       (data_r.fmt),
    .ovfl_rslt (ovfl_rslt_s)
  );

  // Final result/flag select; the special override suppresses rounding flags.
  always_comb begin
    rslt_s   = {RSLT_W{1'b0}};
    fflags_s = {FLAG_W{1'b0}};
    if (!ex3_vld_r) begin
      rslt_s   = {RSLT_W{1'b0}};
      fflags_s = {FLAG_W{1'b0}};
    end else if (data_r.spec_vld) begin
      rslt_s            = data_r.spec_rslt;
      fflags_s[FLAG_NV] = data_r.spec_nv;
    end else begin
      if (ovf_s) rslt_s = ovfl_rslt_s;
      else       rslt_s = norm_rslt_s;
      fflags_s[FLAG_OF] = ovf_s;
      fflags_s[FLAG_UF] = (e_s == 12'd0) & data_r.nx;
      fflags_s[FLAG_NX] = data_r.nx | ovf_s;
    end
  end

  assign ex_if.ex3_rslt_vld = ex3_vld_r;
  assign ex_if.ex3_rslt     = rslt_s;
  assign ex_if.ex3_fflags   = fflags_s;

endmodule

// File: doc/aq_fadd_ex3_pack.md
Name: aq_fadd_ex3_pack

Overview:
EX3 stage of the vector FP adder, directly downstream of the EX2 rounding stage.
- Registers the rounded mantissa results, sign, exponent and the EX2 inexact flag.
- Performs exponent carry-adjust, denormal/overflow detection and IEEE packing for FP64/FP32/FP16/BF16.
- Produces the NaN-boxed 64-bit result and fflags, with stall back-pressure and flush.

Parameters:
- RSLT_W, 64, packed result width.
- FLAG_W, 5, fflags width, ordered {NV,DZ,OF,UF,NX}.

Ports:
- forever_cpuclk  in  1  clock.
- cpurst  in  1  synchronous, active-high reset.
- ex2_vld  in  1  EX2 holds a valid op.
- ex2_fmt  in  2  00 FP64, 01 FP32, 10 FP16, 11 BF16.
- ex2_rm  in  3  rounding mode, RISC-V encoding (only the overflow choice uses it).
- ex2_act_s  in  1  result sign.
- ex2_expnt  in  12  biased exponent of the hidden-bit position, unsigned.
- ex2_double_addsub_rslt  in  54  [53] round carry, [52] hidden bit, [51:0] fraction.
- ex2_single0_addsub_rslt  in  25  same layout: carry 24, hidden 23.
- ex2_half0_addsub_rslt  in  12  same layout: carry 11, hidden 10.
- ex2_bhalf0_addsub_rslt  in  9  same layout: carry 8, hidden 7.
- ex2_nx  in  1  inexact from rounding.
- ex2_special_value_vld  in  1  special result override.
- ex2_special_rslt  in  64  pre-packed special result.
- ex2_special_nv  in  1  invalid flag for the special result.
- ex3_stall  in  1  downstream not ready.
- pipe_flush  in  1  kill in-flight op.
- ex2_stall  out  1  back-pressure to EX2.
- ex3_rslt_vld  out  1  result valid.
- ex3_rslt  out  64  packed result; narrow formats NaN-boxed (upper bits all 1).
- ex3_fflags  out  5  exception flags.

Behaviour:
Pipeline control:
- Single register stage, latency 1 cycle from an EX2 capture to ex3_rslt_vld.
- ex2_stall = ex3_vld & ex3_stall, combinational.
- Capture condition: ex2_vld & !ex2_stall & !pipe_flush.
- Load enable: capture, or (ex3_vld & !ex3_stall).
- ex3_vld next value: 0 when cpurst or pipe_flush; otherwise capture ? 1 : (ex3_stall ? ex3_vld : 0).
- pipe_flush takes priority over capture in the same cycle.
- While stalled, all data registers hold their values.
- Outputs are computed combinationally from the EX3 registers:
  - ex3_rslt_vld = ex3_vld.
  - ex3_rslt and ex3_fflags are forced to 0 when ex3_vld is 0.
- Reset: every register and output is 0, and ex2_stall is 0.
- Reset mid-stall drops the held op; no output appears.

Packing, per format. Let M = the selected mantissa, c = M carry bit, h = M hidden bit.
- Exponent:
  - c=1: E = expnt+1, fraction = M[hidden:1].
  - c=0 and h=1: E = expnt, fraction = M[hidden-1:0].
  - c=0 and h=0: denormal or zero, E = 0, fraction = M[hidden-1:0].
- Max exponent EMAX: 2047, 255, 31, 255 by format.
- Overflow when E >= EMAX. Then OF=1 and NX=1. Result:
  - Infinity if rm is RNE or RMM, RUP with positive sign, or RDN with negative sign.
  - Otherwise the max finite value: E = EMAX-1, fraction all 1s.
- UF = (E == 0) & ex2_nx.
- NX = ex2_nx | OF.
- Exact zero result: if c=h=0 and M=0, sign comes from ex2_act_s as given (EX2 already applies the rm sign rule).
- Special override: ex2_special_value_vld registered → ex3_rslt = special_rslt and fflags = {nv,0,0,0,0}; rounding flags suppressed.
- Exponent arithmetic is 12-bit unsigned. expnt+1 must not wrap, because EX2 guarantees expnt <= EMAX.

Decomposition:
- aq_fadd_pkg holds:
  - Format encodings (FMT_D/S/H/BF).
  - RM encodings.
  - EMAX and fraction width per format.
  - fflags bit positions.
- One sub-module: aq_fadd_ex3_ovfl_sel, combinational overflow-result select (inputs: sign, rm, fmt; output: 64-bit inf/max-finite pattern).

Test Plan:
- FP64, expnt=0x3FF, M=0x10_0000_0000_0000 (h=1), nx=0 → rslt=0x3FF0_0000_0000_0000, flags 0, vld one cycle after ex2_vld.
- FP32 round carry: expnt=0x7E, M[24]=1, nx=1 → rslt=0xFFFF_FFFF_3F80_0000, flags NX.
- FP16 overflow: expnt=30, c=1, sign=0 → rm RNE gives 0x...FFFF_7C00 with OF|NX; rm RTZ gives 0x...FFFF_7BFF.
- BF16 denormal: h=0, M=0x040, nx=1 → rslt low half 0x0040, flags UF|NX.
- Stall/flush:
  - Capture op A, hold ex3_stall=1 for 3 cycles → ex2_stall=1 and rslt stable for 3 cycles; op B released on the first unstalled cycle.
  - pipe_flush together with ex2_vld → ex3_rslt_vld stays 0.
- Special path: special_vld=1, special_nv=1, special_rslt=0x7FF8_0000_0000_0000, nx=1 → rslt passes through unchanged, fflags=5'b10000.
